// File: rtl/rdmx_filter.sv
// rdmx_filter: forwards RDMX-over-UDP frames from a raw Ethernet AXI-Stream
// and discards everything else. The first beat of each frame is decoded as a
// header (ethertype, IP protocol, RDMX magic); accepted frames pass through a
// two-entry skid buffer and all other frames are consumed and dropped.
//
// Optional build macro: RDMX_PORT_CHECK_EN -- when defined, acceptance also
// requires UDP destination port == RDMX_PORT.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   AXIS_IN_T{DATA,KEEP,VALID,LAST} / AXIS_IN_TREADY
//                                raw frames from the MAC, byte 0 in TDATA[7:0]
//   AXIS_RDMX_T{DATA,KEEP,VALID,LAST} / AXIS_RDMX_TREADY
//                                accepted RDMX frames to the receive stage
//   frames_passed, frames_dropped  wrapping 32-bit frame counters
module rdmx_filter #(
  parameter int unsigned DATA_WBITS = 512,
  parameter logic [15:0] RDMX_MAGIC = 16'h0122,
  parameter int unsigned RDMX_PORT  = 32002
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WBITS-1:0]     AXIS_IN_TDATA,
  input  logic [DATA_WBITS/8-1:0]   AXIS_IN_TKEEP,
  input  logic                      AXIS_IN_TVALID,
  input  logic                      AXIS_IN_TLAST,
  output logic                      AXIS_IN_TREADY,
  output logic [DATA_WBITS-1:0]     AXIS_RDMX_TDATA,
  output logic [DATA_WBITS/8-1:0]   AXIS_RDMX_TKEEP,
  output logic                      AXIS_RDMX_TVALID,
  output logic                      AXIS_RDMX_TLAST,
  input  logic                      AXIS_RDMX_TREADY,
  output logic [31:0]               frames_passed,
  output logic [31:0]               frames_dropped
);

  localparam int unsigned DATA_WBYTS = DATA_WBITS / 8;
  localparam logic [15:0] PORT_16    = 16'(RDMX_PORT);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

  state_t                  state;
  logic [DATA_WBITS-1:0]   skid_data;
  logic [DATA_WBYTS-1:0]   skid_keep;
  logic                    skid_last;
  logic                    skid_valid;

  logic [15:0] ethertype_c;
  logic [7:0]  protocol_c;
  logic [15:0] magic_c;
  logic        hdr_ok_c;
  logic        in_hs_c;
  logic        push_c;
  logic        pop_c;
  logic [1:0]  occ_nxt_c;
  logic        free_nxt_c;

  // Header field extraction (big-endian byte order on the wire)
  assign ethertype_c = {AXIS_IN_TDATA[12*8 +: 8], AXIS_IN_TDATA[13*8 +: 8]};
  assign protocol_c  = AXIS_IN_TDATA[23*8 +: 8];
  assign magic_c     = {AXIS_IN_TDATA[42*8 +: 8], AXIS_IN_TDATA[43*8 +: 8]};

`ifdef RDMX_PORT_CHECK_EN
  logic [15:0] udp_port_c;
  assign udp_port_c = {AXIS_IN_TDATA[36*8 +: 8], AXIS_IN_TDATA[37*8 +: 8]};
  assign hdr_ok_c = (ethertype_c == 16'h0800) && (protocol_c == 8'd17) &&
                    (magic_c == RDMX_MAGIC) && (udp_port_c == PORT_16) &&
                    !AXIS_IN_TLAST;
`else
  logic unused_port;
  assign unused_port = ^PORT_16;
  assign hdr_ok_c = (ethertype_c == 16'h0800) && (protocol_c == 8'd17) &&
                    (magic_c == RDMX_MAGIC) && !AXIS_IN_TLAST;
`endif

  // Handshake, buffer push/pop and next-cycle occupancy (drives registered ready)
  always_comb begin
    in_hs_c    = AXIS_IN_TVALID && AXIS_IN_TREADY;
    push_c     = in_hs_c && ((state == ST_PASS) || ((state == ST_IDLE) && hdr_ok_c));
    pop_c      = AXIS_RDMX_TVALID && AXIS_RDMX_TREADY;
    occ_nxt_c  = 2'(AXIS_RDMX_TVALID) + 2'(skid_valid) + 2'(push_c) - 2'(pop_c);
    free_nxt_c = (occ_nxt_c != 2'd2);
  end

  // Frame FSM, input ready and frame counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      AXIS_IN_TREADY <= 1'b0;
      frames_passed  <= 32'd0;
      frames_dropped <= 32'd0;
    end else begin
      AXIS_IN_TREADY <= free_nxt_c;
      case (state)
        ST_IDLE: begin
          if (in_hs_c) begin
            if (hdr_ok_c) begin
              state         <= ST_PASS;
              frames_passed <= frames_passed + 32'd1;
            end else begin
              frames_dropped <= frames_dropped + 32'd1;
              if (!AXIS_IN_TLAST) begin
                state          <= ST_DROP;
                AXIS_IN_TREADY <= 1'b1;
              end
            end
          end
        end
        ST_PASS: begin
          if (in_hs_c && AXIS_IN_TLAST) state <= ST_IDLE;
        end
        ST_DROP: begin
          // Dropped beats never touch the buffer, so ready stays high here
          if (in_hs_c && AXIS_IN_TLAST) state <= ST_IDLE;
          else                          AXIS_IN_TREADY <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry skid buffer: output register is the head, skid holds the overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      AXIS_RDMX_TVALID <= 1'b0;
      skid_valid       <= 1'b0;
    end else begin
      if (pop_c) begin
        if (skid_valid) begin
          AXIS_RDMX_TDATA <= skid_data;
          AXIS_RDMX_TKEEP <= skid_keep;
          AXIS_RDMX_TLAST <= skid_last;
          skid_valid      <= 1'b0;
        end else begin
          AXIS_RDMX_TVALID <= 1'b0;
        end
      end
      if (push_c) begin
        if (!AXIS_RDMX_TVALID || (pop_c && !skid_valid)) begin
          AXIS_RDMX_TDATA  <= AXIS_IN_TDATA;
          AXIS_RDMX_TKEEP  <= AXIS_IN_TKEEP;
          AXIS_RDMX_TLAST  <= AXIS_IN_TLAST;
          AXIS_RDMX_TVALID <= 1'b1;
        end else begin
          skid_data  <= AXIS_IN_TDATA;
          skid_keep  <= AXIS_IN_TKEEP;
          skid_last  <= AXIS_IN_TLAST;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rdmx_filter.sv
// Scoreboard bench for rdmx_filter: the driver pushes expected output beats
// when a forwarded beat is handshaken; a monitor pops and compares whenever
// the DUT completes an output handshake.
module tb_rdmx_filter;

  localparam int unsigned W = 512;
  localparam int unsigned K = W / 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic [K-1:0] k;
    logic         l;
  } beat_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic [K-1:0] in_keep;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [K-1:0] out_keep;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic [31:0]  frames_passed;
  logic [31:0]  frames_dropped;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    first_out_cyc = -1;
  int    last_hs_cyc   = 0;
  int    hdr_hs_cyc    = 0;
  int    exp_passed    = 0;
  int    exp_dropped   = 0;
  bit    rand_en       = 0;
  bit    ready_fix     = 1;

  rdmx_filter #(.DATA_WBITS(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_IN_TDATA    (in_data),
    .AXIS_IN_TKEEP    (in_keep),
    .AXIS_IN_TVALID   (in_valid),
    .AXIS_IN_TLAST    (in_last),
    .AXIS_IN_TREADY   (in_ready),
    .AXIS_RDMX_TDATA  (out_data),
    .AXIS_RDMX_TKEEP  (out_keep),
    .AXIS_RDMX_TVALID (out_valid),
    .AXIS_RDMX_TLAST  (out_last),
    .AXIS_RDMX_TREADY (out_ready),
    .frames_passed    (frames_passed),
    .frames_dropped   (frames_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: fixed or random, updated just after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) out_ready = 1'($urandom_range(0, 1));
      else         out_ready = ready_fix;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output monitor
  initial forever begin
    beat_t act;
    beat_t exp;
    @(negedge clk);
    if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
    if (out_valid && out_ready && !reset) begin
      act = '{d: out_data, k: out_keep, l: out_last};
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got beat last=%0b with no beat expected", out_last);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL out_beat: got %h expected %h", act, exp);
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [W-1:0] make_hdr(input logic [15:0] et, input logic [7:0] pr,
                                            input logic [15:0] port, input logic [15:0] mg);
    logic [W-1:0] d;
    d = rand_data();
    d[12*8 +: 8] = et[15:8];
    d[13*8 +: 8] = et[7:0];
    d[23*8 +: 8] = pr;
    d[36*8 +: 8] = port[15:8];
    d[37*8 +: 8] = port[7:0];
    d[42*8 +: 8] = mg[15:8];
    d[43*8 +: 8] = mg[7:0];
    return d;
  endfunction

  // Present one beat (called just after a rising edge) and wait for its handshake
  task automatic send_beat(input logic [W-1:0] d, input logic [K-1:0] k,
                           input logic l, input bit fwd);
    bit done;
    done     = 0;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        done        = 1;
        last_hs_cyc = cyc;
        if (fwd) sb.push_back('{d: d, k: k, l: l});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_handshake: got no TREADY within 1000 cycles expected handshake");
    end
  endtask

  task automatic send_frame(input logic [W-1:0] hdr, input int nb, input bit fwd);
    logic [K-1:0] k;
    for (int b = 0; b < nb; b++) begin
      k = (b == nb - 1) ? ({K{1'b1}} >> (b + 1)) : {K{1'b1}};
      send_beat((b == 0) ? hdr : rand_data(), k, 1'(b == nb - 1), fwd);
      if (b == 0) hdr_hs_cyc = last_hs_cyc;
    end
    if (fwd) exp_passed++;
    else     exp_dropped++;
  endtask

  task automatic drain(input string nm);
    bit done;
    done      = 0;
    rand_en   = 0;
    ready_fix = 1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    chk({nm, "_beats_left"}, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_passed"},  64'(frames_passed),  64'(exp_passed));
    chk({nm, "_dropped"}, 64'(frames_dropped), 64'(exp_dropped));
  endtask

  localparam logic [15:0] PORT_OK  = 16'd32002;
  localparam logic [15:0] PORT_BAD = 16'd32003;
  localparam logic [15:0] MAGIC    = 16'h0122;

  initial begin
    bit port_fwd;
    reset    = 1'b1;
    in_data  = '0;
    in_keep  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),       64'd0);
    chk("rst_out_valid", 64'(out_valid),      64'd0);
    chk("rst_passed",    64'(frames_passed),  64'd0);
    chk("rst_dropped",   64'(frames_dropped), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_before_first_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Valid 3-beat frame, first output one cycle after the header handshake
    first_out_cyc = -1;
    send_frame(make_hdr(16'h0800, 8'd17, PORT_OK, MAGIC), 3, 1);
    drain("valid3");
    chk("latency", 64'(first_out_cyc - hdr_hs_cyc), 64'd1);
    chk_counts("valid3");

    // ARP frame dropped, then a valid frame passes intact
    send_frame(make_hdr(16'h0806, 8'd17, PORT_OK, MAGIC), 2, 0);
    send_frame(make_hdr(16'h0800, 8'd17, PORT_OK, MAGIC), 3, 1);
    drain("arp");
    chk_counts("arp");

    // Wrong magic, then a single-beat header with TLAST
    send_frame(make_hdr(16'h0800, 8'd17, PORT_OK, 16'h0123), 3, 0);
    send_frame(make_hdr(16'h0800, 8'd17, PORT_OK, MAGIC), 1, 0);
    drain("magic_single");
    chk_counts("magic_single");

    // Wrong protocol
    send_frame(make_hdr(16'h0800, 8'd6, PORT_OK, MAGIC), 2, 0);
    drain("proto");
    chk_counts("proto");

    // Port mismatch: only filtered when the port check is built in
`ifdef RDMX_PORT_CHECK_EN
    port_fwd = 0;
`else
    port_fwd = 1;
`endif
    send_frame(make_hdr(16'h0800, 8'd17, PORT_BAD, MAGIC), 3, port_fwd);
    drain("port");
    chk_counts("port");

    // 100 back-to-back valid frames under random downstream backpressure
    rand_en = 1;
    for (int i = 0; i < 100; i++)
      send_frame(make_hdr(16'h0800, 8'd17, PORT_OK, MAGIC), 2 + (i % 3), 1);
    drain("random");
    chk_counts("random");

    // Reset while beat 2 of a valid 4-beat frame is presented, buffer holding beat 1
    ready_fix = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send_beat(make_hdr(16'h0800, 8'd17, PORT_OK, MAGIC), {K{1'b1}}, 1'b0, 1);
    reset    = 1'b1;
    in_data  = rand_data();
    in_keep  = {K{1'b1}};
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.delete();
    exp_passed  = 0;
    exp_dropped = 0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid),      64'd0);
    chk("midrst_in_ready",  64'(in_ready),       64'd0);
    chk("midrst_passed",    64'(frames_passed),  64'd0);
    chk("midrst_dropped",   64'(frames_dropped), 64'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    ready_fix = 1;
    send_beat(make_hdr(16'h1234, 8'd99, PORT_OK, 16'h5555), {K{1'b1}}, 1'b0, 0);
    send_beat(rand_data(), {K{1'b1}} >> 4, 1'b1, 0);
    exp_dropped++;
    drain("midrst");
    chk_counts("midrst");

    // A valid frame still passes after the interrupted one
    send_frame(make_hdr(16'h0800, 8'd17, PORT_OK, MAGIC), 2, 1);
    drain("post_rst");
    chk_counts("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
